mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-port memory arbiter for `pipe_MIPS32`. It shares one unified instruction/data memory between three requesters:
- the loader/debug port, which preloads programs and reads results;
- the MEM-stage data port (LW/SW);
- the IF-stage fetch port.

It sequences each access through a fixed-latency memory and guarantees fetch forward progress under sustained data traffic. It sits between the core's stage logic and the memory macro, in the core's phase-1 clock domain.

## Interface
Parameters:
- `AW`, 10, memory word-address width
- `MEM_LAT`, 1, memory read latency in cycles (≥1)
- `MAX_DM_STREAK`, 4, maximum consecutive data grants while a fetch waits (≥1)

Ports:
- `clk1`  in  1  sole clock, rising-edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ld_req`, `ld_we`  in  1  loader request / write
- `ld_addr`  in  AW, `ld_wdata`  in  32
- `ld_gnt`, `ld_rvalid`  out  1; `ld_rdata`  out  32
- `dm_req`, `dm_we`  in  1  data-port request / write
- `dm_addr`  in  AW, `dm_wdata`  in  32
- `dm_gnt`, `dm_rvalid`  out  1; `dm_rdata`  out  32
- `if_req`  in  1  fetch request (read only); `if_addr`  in  AW
- `if_gnt`, `if_rvalid`  out  1; `if_rdata`  out  32
- `halted`  in  1  core HALTED flag; masks `if_req`
- `mem_en`, `mem_we`  out  1; `mem_addr`  out  AW; `mem_wdata`  out  32
- `mem_rdata`  in  32  valid `MEM_LAT` cycles after the `mem_en` cycle
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: sample requests, pick a winner, latch its address, write data and write flag → ACCESS.
  - ACCESS: reads stay `MEM_LAT`+1 cycles; writes stay 1 cycle → RESP.
  - RESP: 1 cycle → IDLE.
- Priority is ld > dm > if, with one override: when `dm_streak` == `MAX_DM_STREAK` and a fetch is pending, fetch wins over dm. Loader still wins over fetch.
- Fetch pending means `if_req` & !`halted`.
- `dm_streak`:
  - increments on each dm grant and saturates at `MAX_DM_STREAK`;
  - clears on each if grant;
  - is unchanged by ld grants.
- `xx_gnt` pulses for one cycle, the first ACCESS cycle. `mem_en` pulses in that same cycle; `mem_we` = latched write flag, also only in that cycle. `mem_addr` and `mem_wdata` hold the latched values throughout ACCESS.
- Reads: `mem_rdata` is captured at the last ACCESS cycle. `xx_rdata` is driven from this register, and `xx_rvalid` pulses one cycle in RESP.
- Writes: `xx_rvalid` pulses in RESP as the write acknowledge; `xx_rdata` = 0.
- Requesters hold req, addr, wdata and we stable until gnt, and deassert req no later than the cycle after gnt. Requests are sampled only in IDLE, so requests seen in ACCESS or RESP are ignored, not queued.
- Only the granted port sees gnt, rvalid or nonzero rdata. All other ports' outputs stay 0.

## Timing
- Reset (async, `rst_n`=0): state IDLE, `dm_streak`=0, and every output 0 (all gnt, rvalid and rdata, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`).
- Reset mid-transaction aborts the transaction. A write whose `mem_en` cycle has passed is complete; otherwise it is dropped.
- Read, with req high in IDLE cycle c:
  - gnt and `mem_en` in c+1;
  - rvalid in c+`MEM_LAT`+2;
  - next IDLE sample in c+`MEM_LAT`+3.
- Write, with req in c: gnt, `mem_en` and `mem_we` in c+1; ack in c+2; next sample in c+3.
- Simultaneous requests are resolved in a single IDLE cycle per the priority and override rules above.
- `halted` rising while a fetch is in ACCESS does not abort it; masking applies from the next IDLE.

## Configuration
- `MIPS32_MEM_ARB_STATS_EN`: when defined, adds the following outputs, reset to 0:
  - `dm_grant_cnt` (16 bit): counts dm grants;
  - `if_stall_cnt` (16 bit): counts IDLE, ACCESS and RESP cycles with fetch pending and no if grant in progress.
- Both counters saturate at 16'hFFFF.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

## Structure
- `mips32_pkg` holds the state enum (IDLE, ACCESS, RESP), the requester enum (REQ_NONE, REQ_LD, REQ_DM, REQ_IF) and the default `AW`.
- One sub-module, `mips32_arb_pick`: combinational winner select from `ld_req`, `dm_req`, masked `if_req` and streak-saturated.
- The FSM, latency counter and capture registers are in the top module.

## Test plan
- Loader writes 85 to address 120, then reads 120 with `MEM_LAT`=1:
  - ack 2 cycles after req;
  - read rvalid 3 cycles after req with `ld_rdata`=85.
- `dm_req` read of 120 and `if_req` of address 0 raised in the same IDLE cycle:
  - dm granted first;
  - if granted at the next IDLE sample, 4 cycles later.
- `dm_req` held continuously with `if_req` high and `MAX_DM_STREAK`=4: grant order dm,dm,dm,dm,if,dm…
- `halted`=1 with `if_req` high: no `if_gnt` ever. A dm write of 130 to address 121 is still granted and acked, and a loader read of 121 returns 130.
- `MEM_LAT`=3 read: `mem_en` in c+1 and rvalid in c+5. Assert `rst_n`=0 in c+3: all outputs 0 immediately, and IDLE after release.
- With `MIPS32_MEM_ARB_STATS_EN`: after the streak scenario, `dm_grant_cnt` and `if_stall_cnt` match the bench-counted values.

Source files
------------

// File: rtl/mips32_mem_arbiter_pkg.sv
// Shared types for the pipe_MIPS32 unified-memory arbiter: FSM states,
// requester identifiers and the default word-address width.
package mips32_pkg;

  localparam int unsigned MIPS32_AW = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_LD   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_IF   = 2'd3
  } arb_req_e;

endpackage

// File: rtl/mips32_mem_arbiter_pick.sv
// Combinational winner select: loader > data > fetch, except that a pending
// fetch beats the data port once the data streak has saturated.
module mips32_arb_pick
  import mips32_pkg::*;
(
  input  logic     ld_req_i,
  input  logic     dm_req_i,
  input  logic     if_pend_i,
  input  logic     streak_sat_i,
  output arb_req_e winner_o
);

  always_comb begin
    winner_o = REQ_NONE;
    if (ld_req_i) begin
      winner_o = REQ_LD;
    end else if (if_pend_i && (streak_sat_i || !dm_req_i)) begin
      winner_o = REQ_IF;
    end else if (dm_req_i) begin
      winner_o = REQ_DM;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter sharing one fixed-latency memory between the
// loader, MEM-stage data and IF-stage fetch ports. Optional access statistics
// are enabled with `define MIPS32_MEM_ARB_STATS_EN.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int unsigned AW            = MIPS32_AW,
  parameter int unsigned MEM_LAT       = 1,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [31:0]   ld_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [31:0]   dm_rdata,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
`ifdef MIPS32_MEM_ARB_STATS_EN
  ,
  output logic [15:0]   dm_grant_cnt,
  output logic [15:0]   if_stall_cnt
`endif
);

  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned SW = $clog2(MAX_DM_STREAK + 1);

  arb_state_e    state_q, state_d;
  arb_req_e      owner_q, owner_d;
  arb_req_e      winner;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] streak_q, streak_d;

  logic if_pend, streak_sat, in_access, in_resp, gnt_cycle, last_access;

  assign if_pend     = if_req & ~halted;
  assign streak_sat  = (streak_q == SW'(MAX_DM_STREAK));
  assign in_access   = (state_q == ST_ACCESS);
  assign in_resp     = (state_q == ST_RESP);
  assign gnt_cycle   = in_access && (lat_q == '0);
  assign last_access = in_access && (we_q || (lat_q == LW'(MEM_LAT)));

  mips32_arb_pick u_pick (
    .ld_req_i     (ld_req),
    .dm_req_i     (dm_req),
    .if_pend_i    (if_pend),
    .streak_sat_i (streak_sat),
    .winner_o     (winner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    lat_d    = lat_q;
    streak_d = streak_q;
    case (state_q)
      ST_IDLE: begin
        if (winner != REQ_NONE) begin
          state_d = ST_ACCESS;
          owner_d = winner;
          lat_d   = '0;
          case (winner)
            REQ_LD: begin
              addr_d = ld_addr; wdata_d = ld_wdata; we_d = ld_we;
            end
            REQ_DM: begin
              addr_d = dm_addr; wdata_d = dm_wdata; we_d = dm_we;
            end
            default: begin
              addr_d = if_addr; wdata_d = '0; we_d = 1'b0;
            end
          endcase
        end
      end
      ST_ACCESS: begin
        // Reads hold ACCESS until the memory data is due, then capture it.
        if (last_access) begin
          state_d = ST_RESP;
          rdata_d = we_q ? '0 : mem_rdata;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = REQ_NONE;
      end
    endcase
    if (gnt_cycle) begin
      if (owner_q == REQ_IF) begin
        streak_d = '0;
      end else if (owner_q == REQ_DM && !streak_sat) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= REQ_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      lat_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      lat_q    <= lat_d;
      streak_q <= streak_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_en    = gnt_cycle;
  assign mem_we    = gnt_cycle & we_q;
  assign mem_addr  = in_access ? addr_q  : '0;
  assign mem_wdata = in_access ? wdata_q : '0;

  assign ld_gnt    = gnt_cycle && (owner_q == REQ_LD);
  assign dm_gnt    = gnt_cycle && (owner_q == REQ_DM);
  assign if_gnt    = gnt_cycle && (owner_q == REQ_IF);
  assign ld_rvalid = in_resp && (owner_q == REQ_LD);
  assign dm_rvalid = in_resp && (owner_q == REQ_DM);
  assign if_rvalid = in_resp && (owner_q == REQ_IF);
  assign ld_rdata  = ld_rvalid ? rdata_q : '0;
  assign dm_rdata  = dm_rvalid ? rdata_q : '0;
  assign if_rdata  = if_rvalid ? rdata_q : '0;

`ifdef MIPS32_MEM_ARB_STATS_EN
  logic [15:0] dm_cnt_q, stall_cnt_q;
  logic        if_active;

  assign if_active = (state_q != ST_IDLE) && (owner_q == REQ_IF);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      dm_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (dm_gnt && dm_cnt_q != '1) begin
        dm_cnt_q <= dm_cnt_q + 16'd1;
      end
      if (if_pend && !if_active && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign dm_grant_cnt = dm_cnt_q;
  assign if_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Randomized and directed bench for mips32_mem_arbiter against a
// transaction-level reference model of priority, streak, timing and memory.
module tb_mips32_mem_arbiter;

  localparam int MAXS = 4;
  localparam int LAT  = 1;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // main instance (MEM_LAT=1)
  logic        rst_n;
  logic        ld_req, ld_we, dm_req, dm_we, if_req, halted;
  logic [9:0]  ld_addr, dm_addr, if_addr, mem_addr;
  logic [31:0] ld_wdata, dm_wdata, ld_rdata, dm_rdata, if_rdata, mem_wdata, mem_rdata;
  logic        ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid;
  logic        mem_en, mem_we, busy;
`ifdef MIPS32_MEM_ARB_STATS_EN
  logic [15:0] dm_grant_cnt, if_stall_cnt;
`endif

  mips32_mem_arbiter #(.AW(10), .MEM_LAT(1), .MAX_DM_STREAK(4)) u_dut (
    .clk1(clk1), .rst_n(rst_n),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MIPS32_MEM_ARB_STATS_EN
    , .dm_grant_cnt(dm_grant_cnt), .if_stall_cnt(if_stall_cnt)
`endif
  );

  // second instance (MEM_LAT=3), only the loader port is exercised
  logic        b_rst_n, b_ld_req, b_ld_we;
  logic [9:0]  b_ld_addr, b_mem_addr;
  logic [31:0] b_ld_wdata, b_ld_rdata, b_dm_rdata, b_if_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_ld_gnt, b_ld_rvalid, b_dm_gnt, b_dm_rvalid, b_if_gnt, b_if_rvalid;
  logic        b_mem_en, b_mem_we, b_busy;
  logic        zero1 = 1'b0;
  logic [9:0]  zero10 = '0;
  logic [31:0] zero32 = '0;
`ifdef MIPS32_MEM_ARB_STATS_EN
  logic [15:0] b_dm_grant_cnt, b_if_stall_cnt;
`endif

  mips32_mem_arbiter #(.AW(10), .MEM_LAT(3), .MAX_DM_STREAK(4)) u_dut3 (
    .clk1(clk1), .rst_n(b_rst_n),
    .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
    .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
    .dm_req(zero1), .dm_we(zero1), .dm_addr(zero10), .dm_wdata(zero32),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .if_req(zero1), .if_addr(zero10),
    .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .halted(zero1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
`ifdef MIPS32_MEM_ARB_STATS_EN
    , .dm_grant_cnt(b_dm_grant_cnt), .if_stall_cnt(b_if_stall_cnt)
`endif
  );

  // memory macros: data valid only in the cycle MEM_LAT after mem_en
  logic [31:0] env_mem  [int];
  logic [31:0] env_mem3 [int];
  logic [31:0] rp1, p0, p1, p2;
  assign mem_rdata   = rp1;
  assign b_mem_rdata = p2;

  always @(posedge clk1) begin
    if (mem_en && mem_we) env_mem[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we)
      rp1 <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : 32'd0;
    else
      rp1 <= 32'h5A5A_0000 ^ cyc;
    if (b_mem_en && b_mem_we) env_mem3[int'(b_mem_addr)] = b_mem_wdata;
    if (b_mem_en && !b_mem_we)
      p0 <= env_mem3.exists(int'(b_mem_addr)) ? env_mem3[int'(b_mem_addr)] : 32'd0;
    else
      p0 <= 32'hA5A5_0000 ^ cyc;
    p1 <= p0;
    p2 <= p1;
  end

  // grant/response monitor on the main instance
  int          gnt_log[$];
  int          last_gnt_cyc [4];
  int          last_rv_cyc  [4];
  logic [31:0] last_ld_rdata;
  always @(negedge clk1) begin
    if (ld_gnt) begin gnt_log.push_back(1); last_gnt_cyc[1] = cyc; end
    if (dm_gnt) begin gnt_log.push_back(2); last_gnt_cyc[2] = cyc; end
    if (if_gnt) begin gnt_log.push_back(3); last_gnt_cyc[3] = cyc; end
    if (ld_rvalid) begin last_rv_cyc[1] = cyc; last_ld_rdata = ld_rdata; end
    if (dm_rvalid) last_rv_cyc[2] = cyc;
    if (if_rvalid) last_rv_cyc[3] = cyc;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [int];
  int          streak = 0;
  bit          if_active = 0;
  int          exp_dm_cnt = 0, exp_stall = 0;
  int          req_cyc = 0;
  bit          ld_p = 0, ld_w = 0, dm_p = 0, dm_w = 0, if_p = 0, halt_v = 0;
  logic [9:0]  ld_a = '0, dm_a = '0, if_a = '0;
  logic [31:0] ld_d = '0, dm_d = '0;
  bit          renew = 0;

  task automatic drive();
    ld_req = ld_p; ld_we = ld_w; ld_addr = ld_a; ld_wdata = ld_d;
    dm_req = dm_p; dm_we = dm_w; dm_addr = dm_a; dm_wdata = dm_d;
    if_req = if_p; if_addr = if_a; halted = halt_v;
  endtask

  task automatic tick();
    if (if_req && !halted && !if_active && rst_n) exp_stall++;
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [31:0] ref_rd(input logic [9:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
  endfunction

  task automatic reset_main();
    ld_p = 0; dm_p = 0; if_p = 0; halt_v = 0;
    drive();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid,
                            mem_en, mem_we, busy, |mem_addr, |mem_wdata,
                            |ld_rdata, |dm_rdata, |if_rdata}, 32'd0);
`ifdef MIPS32_MEM_ARB_STATS_EN
    check("reset_stats", {dm_grant_cnt, if_stall_cnt}, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    streak = 0; if_active = 0; exp_dm_cnt = 0; exp_stall = 0;
  endtask

  // one arbitration round starting in an IDLE cycle
  task automatic do_round();
    int          w;
    logic [9:0]  a;
    logic        we;
    logic [31:0] wd, exp_rd, got_rd;
    bit          ifp;
    drive();
    req_cyc = cyc;
    check("idle_quiet", {busy, ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid, mem_en}, 32'd0);
    ifp = if_p && !halt_v;
    if (ld_p) w = 1;
    else if (ifp && (streak == MAXS || !dm_p)) w = 3;
    else if (dm_p) w = 2;
    else w = 0;
    if (w == 0) begin
      tick();
      return;
    end
    case (w)
      1: begin a = ld_a; we = ld_w; wd = ld_d; end
      2: begin a = dm_a; we = dm_w; wd = dm_d; end
      default: begin a = if_a; we = 1'b0; wd = '0; end
    endcase
    tick();
    if_active = (w == 3);
    check("gnt", {ld_gnt, dm_gnt, if_gnt}, 32'(3'b100 >> (w - 1)));
    check("mem_en", mem_en, 1);
    check("mem_we", mem_we, we);
    check("mem_addr", mem_addr, a);
    if (we) check("mem_wdata", mem_wdata, wd);
    if (w == 1) ld_p = 0;
    if (w == 2) begin dm_p = 0; exp_dm_cnt++; if (streak < MAXS) streak++; end
    if (w == 3) begin if_p = 0; streak = 0; end
    if (renew) begin
      if (!dm_p) begin dm_p = 1; dm_w = 0; dm_a = 10'($urandom_range(0, 31)); end
      if (!if_p) begin if_p = 1; if_a = 10'($urandom_range(0, 31)); end
    end
    drive();
    if (we) ref_mem[int'(a)] = wd;
    exp_rd = we ? 32'd0 : ref_rd(a);
    if (!we) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        tick();
        check("access_hold", {busy, ld_gnt, dm_gnt, if_gnt, mem_en, ld_rvalid, dm_rvalid, if_rvalid}, 32'h80);
      end
    end
    tick();
    check("rvalid", {ld_rvalid, dm_rvalid, if_rvalid}, 32'(3'b100 >> (w - 1)));
    case (w)
      1: begin got_rd = ld_rdata; check("rdata_other", dm_rdata | if_rdata, 0); end
      2: begin got_rd = dm_rdata; check("rdata_other", ld_rdata | if_rdata, 0); end
      default: begin got_rd = if_rdata; check("rdata_other", ld_rdata | dm_rdata, 0); end
    endcase
    check("rdata", got_rd, exp_rd);
    tick();
    if_active = 0;
  endtask

  int n_if;

  initial begin
    b_rst_n = 1'b0; b_ld_req = 0; b_ld_we = 0; b_ld_addr = '0; b_ld_wdata = '0;
    reset_main();
    tick();

    // loader write 85 -> 120, then read back
    ld_p = 1; ld_w = 1; ld_a = 10'd120; ld_d = 32'd85;
    do_round();
    check("ld_wr_ack_lat", last_rv_cyc[1] - req_cyc, 2);
    ld_p = 1; ld_w = 0;
    do_round();
    check("ld_rd_lat", last_rv_cyc[1] - req_cyc, 3);
    check("ld_rd_data", last_ld_rdata, 85);

    // dm read and fetch raised together
    dm_p = 1; dm_w = 0; dm_a = 10'd120; if_p = 1; if_a = 10'd0;
    do_round();
    do_round();
    check("dm_first_lat", last_gnt_cyc[2] - req_cyc, 32'(-3));
    check("if_after_dm", last_gnt_cyc[3] - last_gnt_cyc[2], 4);

    // streak: dm held, fetch held
    reset_main();
    gnt_log.delete();
    renew = 1; dm_p = 1; dm_w = 0; if_p = 1;
    for (int i = 0; i < 6; i++) do_round();
    check("streak_len", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++)
      check($sformatf("streak_order%0d", i), gnt_log[i], (i == 4) ? 3 : 2);
`ifdef MIPS32_MEM_ARB_STATS_EN
    check("dm_grant_cnt", dm_grant_cnt, exp_dm_cnt);
    check("if_stall_cnt", if_stall_cnt, exp_stall);
`endif
    renew = 0; dm_p = 0; if_p = 0;
    do_round();

    // halted masks fetch
    gnt_log.delete();
    halt_v = 1; if_p = 1; if_a = 10'd4;
    dm_p = 1; dm_w = 1; dm_a = 10'd121; dm_d = 32'd130;
    do_round();
    ld_p = 1; ld_w = 0; ld_a = 10'd121;
    do_round();
    for (int i = 0; i < 3; i++) do_round();
    n_if = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 3) n_if++;
    check("halted_no_if", n_if, 0);
    check("halted_ld_rd", last_ld_rdata, 130);
    halt_v = 0; if_p = 0;
    do_round();

    // randomized traffic
    for (int r = 0; r < 300; r++) begin
      if (!ld_p && $urandom_range(0, 5) == 0) begin
        ld_p = 1; ld_w = $urandom_range(0, 1); ld_a = 10'($urandom_range(0, 31)); ld_d = $urandom;
      end
      if (!dm_p && $urandom_range(0, 1) == 1) begin
        dm_p = 1; dm_w = $urandom_range(0, 1); dm_a = 10'($urandom_range(0, 31)); dm_d = $urandom;
      end
      if (!if_p && $urandom_range(0, 1) == 1) begin
        if_p = 1; if_a = 10'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) halt_v = !halt_v;
      do_round();
    end
`ifdef MIPS32_MEM_ARB_STATS_EN
    check("dm_grant_cnt_rand", dm_grant_cnt, exp_dm_cnt);
    check("if_stall_cnt_rand", if_stall_cnt, exp_stall);
`endif
    ld_p = 0; dm_p = 0; if_p = 0; halt_v = 0;
    drive();

    // MEM_LAT=3 instance: write, read latency, reset mid-read
    tick();
    b_rst_n = 1'b1;
    b_ld_req = 1; b_ld_we = 1; b_ld_addr = 10'd5; b_ld_wdata = 32'hABCD_1234;
    tick();
    check("l3_wr_gnt", {b_ld_gnt, b_mem_en, b_mem_we}, 32'b111);
    b_ld_req = 0;
    tick();
    check("l3_wr_ack", {b_ld_rvalid, |b_ld_rdata}, 32'b10);
    tick();
    b_ld_req = 1; b_ld_we = 0;
    tick();
    check("l3_rd_gnt", {b_ld_gnt, b_mem_en, b_mem_we}, 32'b110);
    b_ld_req = 0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("l3_no_rv_c%0d", i), b_ld_rvalid, 0);
    end
    tick();
    check("l3_rv_c5", b_ld_rvalid, 1);
    check("l3_rdata", b_ld_rdata, 32'hABCD_1234);
    tick();
    check("l3_idle", b_busy, 0);
    b_ld_req = 1;
    tick();
    check("l3_rd2_en", b_mem_en, 1);
    b_ld_req = 0;
    tick();
    tick();
    b_rst_n = 1'b0;
    #1;
    check("l3_reset_outputs", {b_ld_gnt, b_ld_rvalid, b_dm_gnt, b_dm_rvalid, b_if_gnt, b_if_rvalid,
                               b_mem_en, b_mem_we, b_busy, |b_mem_addr, |b_mem_wdata,
                               |b_ld_rdata, |b_dm_rdata, |b_if_rdata}, 32'd0);
    tick();
    b_rst_n = 1'b1;
    check("l3_idle_after_rst", b_busy, 0);
    b_ld_req = 1;
    tick();
    check("l3_rd3_gnt", b_ld_gnt, 1);
    b_ld_req = 0;
    repeat (4) tick();
    check("l3_rd3_rv", b_ld_rvalid, 1);
    check("l3_rd3_data", b_ld_rdata, 32'hABCD_1234);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
